// File: rtl/mackerel_bus_ack.sv
// mackerel_bus_ack: 68000 DTACK generator with per-region wait states and BERR watchdog
module mackerel_bus_ack #(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 0,
    parameter int BERR_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       ROMEN,
    input  logic [3:0] RAMEN,
    input  logic       MFPEN,
    input  logic       IACK,
    input  logic       DTACK_MFP,
    output logic       DTACK,
    output logic       BERR,
    output logic [7:0] BERR_COUNT
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, FAULT} state_t;
    typedef enum logic [1:0] {C_NONE, C_ROM, C_RAM, C_MFP} cls_t;

    localparam logic [CNT_W-1:0] ROM_W = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(BERR_TIMEOUT);

    state_t           state, state_n;
    cls_t             cls, cls_n, cls_in;
    logic [CNT_W-1:0] cnt, cnt_n, start_w, cur_w;
    logic             start_mem, cur_mem, done, dtack_d, berr_d, fault_entry;

    // State, class, counter and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cls        <= C_NONE;
            cnt        <= '0;
            DTACK      <= 1'b1;
            BERR       <= 1'b1;
            BERR_COUNT <= 8'd0;
        end else begin
            state      <= state_n;
            cls        <= cls_n;
            cnt        <= cnt_n;
            DTACK      <= dtack_d;
            BERR       <= berr_d;
            BERR_COUNT <= BERR_COUNT + {7'd0, fault_entry && BERR_COUNT != 8'hFF};
        end
    end

    // Next state: classify at cycle start, then wait for ack, timeout or abort
    always_comb begin
        cls_in    = !IACK ? C_MFP : !ROMEN ? C_ROM : (RAMEN != 4'hF) ? C_RAM : !MFPEN ? C_MFP : C_NONE;
        start_mem = cls_in == C_ROM || cls_in == C_RAM;
        start_w   = cls_in == C_ROM ? ROM_W : RAM_W;
        cur_mem   = cls == C_ROM || cls == C_RAM;
        cur_w     = cls == C_ROM ? ROM_W : RAM_W;
        done      = cur_mem ? cnt == cur_w : cls == C_MFP && !DTACK_MFP;
        state_n   = state;
        cls_n     = cls;
        cnt_n     = cnt;
        case (state)
            IDLE: begin
                cls_n   = AS ? cls : cls_in;
                cnt_n   = AS ? '0 : CNT_W'(1);
                state_n = AS ? IDLE : (start_mem && start_w == '0) ? ACK : WAIT;
            end
            WAIT: begin
                state_n = AS ? IDLE : done ? ACK : cnt == TMO ? FAULT : WAIT;
                cnt_n   = AS ? '0 : cnt == TMO ? cnt : cnt + CNT_W'(1);
            end
            ACK:     state_n = AS ? IDLE : ACK;
            default: state_n = AS ? IDLE : FAULT;
        endcase
    end

    // Output decode from the next state so the pins change on the deciding edge
    always_comb begin
        dtack_d     = state_n != ACK;
        berr_d      = state_n != FAULT;
        fault_entry = state_n == FAULT && state != FAULT;
    end
endmodule
